// File: rtl/nmea_rmc_decoder.sv
// Streaming decoder for NMEA $GPRMC/$GNRMC sentences: one character per valid clk,
// extracts UTC time/date, fix status and hemispheres, and commits them atomically at LF.
module nmea_rmc_decoder #(
  parameter bit CHECK_CSUM = 1'b1,
  parameter bit ACCEPT_GN  = 1'b1,
  parameter int MAX_LEN    = 82
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char,
  input  logic       valid,
  output logic       NSR,
  output logic       csum_err,
  output logic       fmt_err,
  output logic [4:0] hr,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic [4:0] day,
  output logic [3:0] mon,
  output logic [6:0] yr,
  output logic       fix,
  output logic       lat_s,
  output logic       lon_w
);
  localparam int LW = $clog2(MAX_LEN + 2);

  typedef enum logic [2:0] {IDLE, HDR, FIELDS, CS_HI, CS_LO, WAIT_CR, WAIT_LF} state_t;
  state_t state, nstate;

  logic [2:0]    hdr_idx, pos;
  logic [3:0]    fld;
  logic [LW-1:0] len;
  logic [7:0]    xacc, rx_cs;
  logic [6:0]    sh_hr, sh_min, sh_sec, sh_day, sh_mon, sh_yr;
  logic          sh_fix, sh_lat, sh_lon;
  logic          seen_time, seen_stat, have_ns, have_ew, have_date;

  logic       is_dig, is_hex, is_cr, is_lf, hdr_ok, over, close_bad, char_bad;
  logic [3:0] dval, hval;
  logic       err_mid, eos, fields_ok, fmt_d, cse_d, commit_d, cap;

  assign is_dig = (char >= "0") && (char <= "9");
  assign is_hex = is_dig || ((char >= "A") && (char <= "F")) || ((char >= "a") && (char <= "f"));
  assign is_cr  = (char == 8'h0D);
  assign is_lf  = (char == 8'h0A);
  assign dval   = char[3:0];
  assign hval   = is_dig ? char[3:0] : char[3:0] + 4'd9;
  assign over   = (len >= LW'(MAX_LEN));

  always_comb begin
    hdr_ok = 1'b0;
    case (hdr_idx)
      3'd0: hdr_ok = (char == "G");
      3'd1: hdr_ok = (char == "P") || (ACCEPT_GN && (char == "N"));
      3'd2: hdr_ok = (char == "R");
      3'd3: hdr_ok = (char == "M");
      3'd4: hdr_ok = (char == "C");
      default: hdr_ok = 1'b0;
    endcase
  end

  // Range/completeness checks run when a field closes; per-char checks run on capture.
  always_comb begin
    close_bad = 1'b0;
    char_bad  = 1'b0;
    case (fld)
      4'd1: begin
        close_bad = (pos < 3'd6) || (sh_hr > 7'd23) || (sh_min > 7'd59) || (sh_sec > 7'd59);
        char_bad  = ((pos < 3'd6) && !is_dig) || ((pos == 3'd6) && (char != "."));
      end
      4'd2: begin
        close_bad = (pos == 3'd0);
        char_bad  = (pos != 3'd0) || !((char == "A") || (char == "V"));
      end
      4'd4: char_bad = (pos != 3'd0) || !((char == "N") || (char == "S"));
      4'd6: char_bad = (pos != 3'd0) || !((char == "E") || (char == "W"));
      4'd9: begin
        close_bad = (pos != 3'd0) && ((pos != 3'd6) || (sh_day == 7'd0) || (sh_day > 7'd31) ||
                                      (sh_mon == 7'd0) || (sh_mon > 7'd12));
        char_bad  = (pos >= 3'd6) || !is_dig;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)        state <= IDLE;
    else if (valid) state <= nstate;
  end

  always_comb begin
    nstate  = state;
    err_mid = 1'b0;
    eos     = 1'b0;
    if (valid) begin
      if (char == "$") begin
        nstate = HDR;
      end else if ((state != IDLE) && over) begin
        err_mid = 1'b1;
        nstate  = IDLE;
      end else begin
        case (state)
          IDLE: ;
          HDR: begin
            if (!hdr_ok)              nstate = IDLE;
            else if (hdr_idx == 3'd4) nstate = FIELDS;
          end
          FIELDS: begin
            if (char == ",") begin
              if (close_bad) begin err_mid = 1'b1; nstate = IDLE; end
            end else if (char == "*") begin
              if (close_bad) begin err_mid = 1'b1; nstate = IDLE; end
              else nstate = CS_HI;
            end else if (is_cr || is_lf) begin
              if (CHECK_CSUM || close_bad) begin err_mid = 1'b1; nstate = IDLE; end
              else if (is_cr) nstate = WAIT_LF;
              else begin eos = 1'b1; nstate = IDLE; end
            end else if (char_bad) begin
              err_mid = 1'b1;
              nstate  = IDLE;
            end
          end
          CS_HI: begin
            if (is_hex) nstate = CS_LO;
            else begin err_mid = 1'b1; nstate = IDLE; end
          end
          CS_LO: begin
            if (is_hex) nstate = WAIT_CR;
            else begin err_mid = 1'b1; nstate = IDLE; end
          end
          WAIT_CR: begin
            if (is_cr) nstate = WAIT_LF;
            else begin err_mid = 1'b1; nstate = IDLE; end
          end
          WAIT_LF: begin
            nstate = IDLE;
            if (is_lf) eos = 1'b1;
            else       err_mid = 1'b1;
          end
          default: nstate = IDLE;
        endcase
      end
    end
  end

  // End-of-sentence precedence: format, then checksum, then commit.
  always_comb begin
    fields_ok = seen_time && seen_stat;
    fmt_d     = err_mid || (eos && !fields_ok);
    cse_d     = eos && fields_ok && CHECK_CSUM && (rx_cs != xacc);
    commit_d  = eos && fields_ok && !cse_d;
    cap       = valid && (state == FIELDS) && (nstate == FIELDS) && (char != ",");
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {NSR, csum_err, fmt_err} <= '0;
      {hr, min, sec, day, mon, yr, fix, lat_s, lon_w} <= '0;
      hdr_idx <= '0; pos <= '0; fld <= '0; len <= '0; xacc <= '0; rx_cs <= '0;
      {sh_hr, sh_min, sh_sec, sh_day, sh_mon, sh_yr, sh_fix, sh_lat, sh_lon} <= '0;
      {seen_time, seen_stat, have_ns, have_ew, have_date} <= '0;
    end else begin
      NSR      <= commit_d;
      fmt_err  <= fmt_d;
      csum_err <= cse_d;
      if (valid && (char == "$")) begin
        hdr_idx <= '0; pos <= '0; fld <= '0; len <= LW'(1); xacc <= '0; rx_cs <= '0;
        {seen_time, seen_stat, have_ns, have_ew, have_date} <= '0;
      end else if (valid && (state != IDLE)) begin
        len <= len + LW'(1);
        if (state == HDR) begin
          hdr_idx <= hdr_idx + 3'd1;
          xacc    <= xacc ^ char;
        end
        if ((state == FIELDS) && (char != "*") && !is_cr && !is_lf) xacc <= xacc ^ char;
        if ((state == FIELDS) && (char == ",") && (nstate == FIELDS)) begin
          if (fld != 4'hF) fld <= fld + 4'd1;
          pos <= '0;
        end
        if (cap) begin
          if (pos != 3'd7) pos <= pos + 3'd1;
          case (fld)
            4'd1: case (pos)
              3'd0: sh_hr  <= 7'(dval) * 7'd10;
              3'd1: sh_hr  <= sh_hr + 7'(dval);
              3'd2: sh_min <= 7'(dval) * 7'd10;
              3'd3: sh_min <= sh_min + 7'(dval);
              3'd4: sh_sec <= 7'(dval) * 7'd10;
              3'd5: begin sh_sec <= sh_sec + 7'(dval); seen_time <= 1'b1; end
              default: ;
            endcase
            4'd2: begin sh_fix <= (char == "A"); seen_stat <= 1'b1; end
            4'd4: begin sh_lat <= (char == "S"); have_ns <= 1'b1; end
            4'd6: begin sh_lon <= (char == "W"); have_ew <= 1'b1; end
            4'd9: case (pos)
              3'd0: sh_day <= 7'(dval) * 7'd10;
              3'd1: sh_day <= sh_day + 7'(dval);
              3'd2: sh_mon <= 7'(dval) * 7'd10;
              3'd3: sh_mon <= sh_mon + 7'(dval);
              3'd4: sh_yr  <= 7'(dval) * 7'd10;
              3'd5: begin sh_yr <= sh_yr + 7'(dval); have_date <= 1'b1; end
              default: ;
            endcase
            default: ;
          endcase
        end
        if ((state == CS_HI) && is_hex) rx_cs[7:4] <= hval;
        if ((state == CS_LO) && is_hex) rx_cs[3:0] <= hval;
      end
      if (commit_d) begin
        hr  <= sh_hr[4:0];
        min <= sh_min[5:0];
        sec <= sh_sec[5:0];
        fix <= sh_fix;
        if (have_ns) lat_s <= sh_lat;
        if (have_ew) lon_w <= sh_lon;
        if (have_date) begin
          day <= sh_day[4:0];
          mon <= sh_mon[3:0];
          yr  <= sh_yr;
        end
      end
    end
  end
endmodule

// File: doc/nmea_rmc_decoder.md
NMEA_RMC_DECODER -- requirements
Module: nmea_rmc_decoder

Interface
REQ-001 Parameter CHECK_CSUM, default 1: 1 = '*hh' checksum mandatory and verified; 0 = checksum optional and ignored.
REQ-002 Parameter ACCEPT_GN, default 1: 1 = accept talker "GN" as well as "GP"; 0 = "GP" only.
REQ-003 Parameter MAX_LEN, default 82: maximum characters per sentence, counted from '$' through LF inclusive.
REQ-004 clk  in  1  single clock, all logic on rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 char  in  8  ASCII character, sampled only when valid=1.
REQ-007 valid  in  1  char qualifier; one character consumed per clk with valid=1.
REQ-008 NSR  out  1  one-cycle pulse: new sentence committed to outputs.
REQ-009 csum_err  out  1  one-cycle pulse: complete RMC sentence rejected on checksum.
REQ-010 fmt_err  out  1  one-cycle pulse: RMC sentence rejected on format, range or length.
REQ-011 hr/min/sec  out  5/6/6  UTC time, binary.
REQ-012 day/mon/yr  out  5/4/7  UTC date, binary, yr 0-99.
REQ-013 fix  out  1  status field: 1 = 'A', 0 = 'V'.
REQ-014 lat_s  out  1  1 = 'S' hemisphere. lon_w  out  1  1 = 'W' hemisphere.

Function
REQ-015 FSM states: IDLE, HDR (5 chars), FIELDS, CS_HI, CS_LO, WAIT_CR, WAIT_LF.
REQ-016 IDLE: discard everything except '$', which clears field index, length counter and XOR accumulator, then enters HDR.
REQ-017 HDR: accepts "GPRMC", or "GNRMC" when ACCEPT_GN=1; any mismatch -> IDLE silently, no pulse.
REQ-018 Checksum: XOR of all characters strictly between '$' and '*'.
REQ-019 FIELDS: ',' increments field index (time = 1, status = 2, N/S = 4, E/W = 6, date = 9); other characters are captured into shadow registers for the current field.
REQ-020 Time field: first 6 characters are digits hhmmss; an optional '.' fraction is ignored; empty field, non-digit, hr>23, min>59 or sec>59 -> format error.
REQ-021 Date field: ddmmyy, all digits; day 1-31, mon 1-12, else format error. An empty date field is allowed; date outputs then hold.
REQ-022 Status other than A/V, N/S other than N/S, or E/W other than E/W -> format error. Empty N/S or E/W fields are allowed; those outputs hold.
REQ-023 '*' in FIELDS -> CS_HI. Hex digits 0-9, A-F and a-f are accepted; a non-hex character -> format error.
REQ-024 CS_LO complete -> WAIT_CR. CR -> WAIT_LF. LF -> end of sentence. Any other character in WAIT_CR or WAIT_LF -> format error.
REQ-025 CR or LF in FIELDS: if CHECK_CSUM=1 -> format error; if CHECK_CSUM=0 -> proceed to end of sentence (CR leads to WAIT_LF).
REQ-026 End of sentence: precedence is format error, then checksum mismatch (CHECK_CSUM=1 only), then commit.
REQ-027 Commit: all shadow values copied to outputs in the same edge; NSR pulses for exactly one cycle, in the cycle after the edge that consumed LF.
REQ-028 Rejected sentence: no output changes; exactly one of fmt_err or csum_err pulses, in the same cycle timing as NSR.
REQ-029 Error timing: format errors detected mid-sentence pulse immediately, then FSM -> IDLE and the rest of the sentence is discarded.
REQ-030 '$' in any state other than IDLE: abandon the current sentence with no pulse and restart at HDR (resync).
REQ-031 Length counter exceeding MAX_LEN -> fmt_err pulse, then IDLE.
REQ-032 valid=0: no state, counter or shadow register changes. Pulses are never longer than one cycle.

Reset
REQ-033 rst=1 at a clock edge forces IDLE, clears shadows, counters and the XOR accumulator, and drives all outputs to 0.
REQ-034 Reset mid-sentence discards the partial sentence; a sentence that starts after reset parses normally.
REQ-035 After reset, outputs stay 0 until the first commit.

Verification
REQ-036 Defaults; "$GPRMC,123519,A,4807.038,N,01131.000,E,022.4,084.4,230394,003.1,W*6A\r\n", one char every 2 clk -> single NSR; hr=12 min=35 sec=19 day=23 mon=3 yr=94 fix=1 lat_s=0 lon_w=0.
REQ-037 Same sentence with checksum "*6B" -> csum_err once, NSR never, outputs unchanged.
REQ-038 Time field "253519" -> fmt_err once, FSM back to IDLE, outputs unchanged; a following valid sentence commits normally.
REQ-039 "$GNRMC..." sentence with ACCEPT_GN=0 -> no pulses; with ACCEPT_GN=1 and checksum recomputed -> NSR.
REQ-040 '$' injected after "$GPRMC,12", then a full valid sentence -> only one NSR, with values from the second sentence.
REQ-041 rst pulsed at char 30 of a valid sentence -> all outputs 0, no pulse; the next valid sentence commits.
